// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first, repeated
// a programmable number of times with an optional run of zero gap bits between copies.
module serial_pattern_tx #(
    parameter int PAT_W = 3,
    parameter int REP_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [REP_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap,
    output logic             d_out,
    output logic             d_valid,
    output logic             busy,
    output logic             done
);

    // state  | meaning
    // IDLE   | waiting for start; all outputs low
    // SEND   | driving pattern bit r_bit_idx on d_out
    // GAP    | driving zero gap bits between copies
    // DONE   | one-cycle done pulse, start ignored

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [PAT_W-1:0] r_pat;
    logic [IDX_W-1:0] r_bit_idx;
    logic [REP_W-1:0] r_copies_left;
    logic [GAP_W-1:0] r_gap_len;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_d_out;
    logic             r_d_valid;
    logic             r_busy;
    logic             r_done;

    logic [IDX_W-1:0] w_idx_dec;
    assign w_idx_dec = r_bit_idx - IDX_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_pat         <= '0;
            r_bit_idx     <= '0;
            r_copies_left <= '0;
            r_gap_len     <= '0;
            r_gap_cnt     <= '0;
            r_d_out       <= 1'b0;
            r_d_valid     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state       <= S_SEND;
                        r_pat         <= pattern;
                        r_gap_len     <= gap;
                        // copies remaining after the one starting now; 0 behaves as 1
                        r_copies_left <= (repeat_n == '0) ? '0 : repeat_n - REP_W'(1);
                        r_bit_idx     <= IDX_MSB;
                        r_d_out       <= pattern[PAT_W-1];
                        r_d_valid     <= 1'b1;
                        r_busy        <= 1'b1;
                    end else begin
                        r_d_out   <= 1'b0;
                        r_d_valid <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (r_bit_idx != '0) begin
                        r_bit_idx <= w_idx_dec;
                        r_d_out   <= r_pat[w_idx_dec];
                    end else if (r_copies_left == '0) begin
                        r_state   <= S_DONE;
                        r_d_out   <= 1'b0;
                        r_d_valid <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (r_gap_len != '0) begin
                        r_state   <= S_GAP;
                        r_gap_cnt <= r_gap_len - GAP_W'(1);
                        r_d_out   <= 1'b0;
                        r_d_valid <= 1'b0;
                    end else begin
                        r_copies_left <= r_copies_left - REP_W'(1);
                        r_bit_idx     <= IDX_MSB;
                        r_d_out       <= r_pat[PAT_W-1];
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state       <= S_SEND;
                        r_copies_left <= r_copies_left - REP_W'(1);
                        r_bit_idx     <= IDX_MSB;
                        r_d_out       <= r_pat[PAT_W-1];
                        r_d_valid     <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_d_out   <= 1'b0;
                    r_d_valid <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign d_out   = r_d_out;
    assign d_valid = r_d_valid;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
